// File: rtl/irq_ctrl.sv
// Prioritised, nestable interrupt controller: N_IRQ sources with per-source mask, edge/level mode,
// software trigger and pending clear, plus a priority stack of accepted interrupts.
module irq_ctrl #(
  parameter int N_IRQ      = 4,
  parameter int VEC_W      = 10,
  parameter int VEC_BASE   = 1008,
  parameter int VEC_STRIDE = 4,
  parameter int NEST_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_IRQ-1:0]                   irq_src,
  input  logic                               cfg_we,
  input  logic [1:0]                         cfg_sel,
  input  logic [N_IRQ-1:0]                   cfg_wdata,
  input  logic                               irq_ack,
  input  logic                               irq_ret,
  output logic                               irq_req,
  output logic [$clog2(N_IRQ)-1:0]           irq_id,
  output logic [VEC_W-1:0]                   irq_vec,
  output logic [N_IRQ-1:0]                   pending,
  output logic [$clog2(NEST_DEPTH+1)-1:0]    nest_level,
  output logic                               irq_err
);

  localparam int ID_W  = $clog2(N_IRQ);
  localparam int LVL_W = $clog2(NEST_DEPTH+1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(NEST_DEPTH);

  typedef enum logic [1:0] {
    SEL_MASK = 2'd0,
    SEL_MODE = 2'd1,
    SEL_CLR  = 2'd2,
    SEL_TRIG = 2'd3
  } cfg_sel_e;

  cfg_sel_e               sel;
  logic [N_IRQ-1:0]       mask, mode, hist;
  logic [ID_W-1:0]        stack [NEST_DEPTH];

  logic [N_IRQ-1:0]       eligible, set_bits, clr_bits;
  logic [ID_W-1:0]        winner, top;
  logic [VEC_W-1:0]       vec_next;
  logic [LVL_W-1:0]       lvl_popped;
  logic                   preempt_ok, accept, pop, push, req_next, err_next;

  assign sel = cfg_sel_e'(cfg_sel);

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    eligible = pending & mask;
    winner   = '0;
    for (int i = N_IRQ-1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end

    top = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (nest_level == LVL_W'(i+1)) top = stack[i];
    end

    preempt_ok = ((nest_level == '0) || (winner < top)) && (nest_level < FULL);
    accept     = irq_ack & irq_req;
    req_next   = (|eligible) && preempt_ok && !accept;

    // Return is applied before accept, so ack+ret in one cycle replaces the top entry.
    pop        = irq_ret && (nest_level != '0);
    lvl_popped = pop ? nest_level - LVL_W'(1) : nest_level;
    push       = accept && (lvl_popped < FULL);
    err_next   = (irq_ret && (nest_level == '0)) || (accept && !push);

    set_bits = (mode & irq_src & ~hist) | (~mode & irq_src);
    if (cfg_we && (sel == SEL_TRIG)) set_bits = set_bits | cfg_wdata;

    clr_bits = '0;
    if (cfg_we && (sel == SEL_CLR)) clr_bits = cfg_wdata;
    if (push) clr_bits[irq_id] = 1'b1;

    vec_next = VEC_W'(VEC_BASE) + VEC_W'(VEC_STRIDE) * VEC_W'(winner);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      mode       <= '0;
      hist       <= '0;
      pending    <= '0;
      nest_level <= '0;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_vec    <= VEC_W'(VEC_BASE);
      irq_err    <= 1'b0;
    end else begin
      hist <= irq_src;
      if (cfg_we && (sel == SEL_MASK)) mask <= cfg_wdata;
      if (cfg_we && (sel == SEL_MODE)) mode <= cfg_wdata;
      // Set conditions are ORed in after the clear, so a same-cycle set wins.
      pending    <= (pending & ~clr_bits) | set_bits;
      nest_level <= push ? lvl_popped + LVL_W'(1) : lvl_popped;
      if (err_next) irq_err <= 1'b1;
      irq_req <= req_next;
      if (req_next) begin
        irq_id  <= winner;
        irq_vec <= vec_next;
      end
    end
  end

  // NOTE: stack storage is not reset; nest_level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (lvl_popped == LVL_W'(i)) stack[i] <= irq_id;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations are queued as stimulus is driven and
// compared against the DUT outputs one cycle later.
module tb_irq_ctrl;

  localparam int N_IRQ      = 4;
  localparam int VEC_W      = 10;
  localparam int NEST_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       irq_src = '0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_sel = '0;
  logic [3:0]       cfg_wdata = '0;
  logic             irq_ack = 1'b0;
  logic             irq_ret = 1'b0;
  logic             irq_req;
  logic [1:0]       irq_id;
  logic [9:0]       irq_vec;
  logic [3:0]       pending;
  logic [2:0]       nest_level;
  logic             irq_err;

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_IRQ(N_IRQ), .VEC_W(VEC_W), .VEC_BASE(1008), .VEC_STRIDE(4), .NEST_DEPTH(NEST_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .irq_ack(irq_ack), .irq_ret(irq_ret), .irq_req(irq_req),
    .irq_id(irq_id), .irq_vec(irq_vec), .pending(pending), .nest_level(nest_level),
    .irq_err(irq_err)
  );

  typedef enum {O_REQ, O_ID, O_VEC, O_PEND, O_LVL, O_ERR} out_e;
  typedef struct {
    string       tag;
    out_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic expect_out(input string tag, input out_e sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input out_e sel);
    case (sel)
      O_REQ:   return 32'(irq_req);
      O_ID:    return 32'(irq_id);
      O_VEC:   return 32'(irq_vec);
      O_PEND:  return 32'(pending);
      O_LVL:   return 32'(nest_level);
      O_ERR:   return 32'(irq_err);
      default: return '0;
    endcase
  endfunction

  // One clock edge, then release strobes and check everything queued for this edge.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    irq_ack = 1'b0;
    irq_ret = 1'b0;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
  endtask

  task automatic exp_reqd(input string tag, input int id);
    expect_out({tag, "_req"}, O_REQ, 1);
    expect_out({tag, "_id"},  O_ID,  id);
    expect_out({tag, "_vec"}, O_VEC, 1008 + 4 * id);
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    irq_src = '0;
    expect_out({tag, "_req"},  O_REQ,  0);
    expect_out({tag, "_id"},   O_ID,   0);
    expect_out({tag, "_vec"},  O_VEC,  1008);
    expect_out({tag, "_pend"}, O_PEND, 0);
    expect_out({tag, "_lvl"},  O_LVL,  0);
    expect_out({tag, "_err"},  O_ERR,  0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Edge-mode source 0: two-cycle latency, one request per rising edge.
    do_reset("rst0");
    cfg(2'd0, 4'b1111); step();
    cfg(2'd1, 4'b0001); step();
    irq_src = 4'b0001;
    expect_out("t1_pend", O_PEND, 1); expect_out("t1_noreq", O_REQ, 0); step();
    irq_src = 4'b0000;
    exp_reqd("t1", 0); step();
    irq_ack = 1'b1;
    expect_out("t1_ack_lvl", O_LVL, 1); expect_out("t1_ack_req", O_REQ, 0);
    expect_out("t1_ack_pend", O_PEND, 0); step();
    irq_ret = 1'b1; expect_out("t1_ret_lvl", O_LVL, 0); step();
    irq_src = 4'b0001;
    expect_out("t1_pend2", O_PEND, 1); step();
    exp_reqd("t1b", 0); step();
    irq_ack = 1'b1;
    expect_out("t1b_ack_req", O_REQ, 0); expect_out("t1b_ack_pend", O_PEND, 0); step();
    irq_ret = 1'b1; expect_out("t1b_ret_lvl", O_LVL, 0); step();
    repeat (10) begin
      expect_out("t1_hold_req", O_REQ, 0); expect_out("t1_hold_pend", O_PEND, 0); step();
    end
    irq_src = 4'b0000;

    // Level source 2: re-pends under ack, blocked at equal priority, served after return.
    do_reset("rst2");
    cfg(2'd0, 4'b0100); step();
    irq_src = 4'b0100;
    expect_out("t2_pend", O_PEND, 4'b0100); expect_out("t2_noreq", O_REQ, 0); step();
    exp_reqd("t2", 2); step();
    irq_ack = 1'b1;
    expect_out("t2_ack_req", O_REQ, 0); expect_out("t2_ack_pend", O_PEND, 4'b0100);
    expect_out("t2_ack_lvl", O_LVL, 1); step();
    expect_out("t2_blocked", O_REQ, 0); expect_out("t2_blk_lvl", O_LVL, 1); step();
    irq_ret = 1'b1;
    expect_out("t2_ret_lvl", O_LVL, 0); expect_out("t2_ret_req", O_REQ, 0); step();
    exp_reqd("t2_rereq", 2); step();
    irq_src = 4'b0000;

    // Nesting with software triggers.
    do_reset("rst3");
    cfg(2'd0, 4'b1111); step();
    cfg(2'd3, 4'b1000);
    expect_out("t3_pend3", O_PEND, 4'b1000); expect_out("t3_noreq", O_REQ, 0); step();
    exp_reqd("t3_id3", 3); step();
    irq_ack = 1'b1;
    expect_out("t3_lvl1", O_LVL, 1); expect_out("t3_pend0", O_PEND, 0); step();
    cfg(2'd3, 4'b0010); expect_out("t3_pend1", O_PEND, 4'b0010); step();
    exp_reqd("t3_id1", 1); step();
    irq_ack = 1'b1; expect_out("t3_lvl2", O_LVL, 2); expect_out("t3_req0", O_REQ, 0); step();
    cfg(2'd3, 4'b0100); expect_out("t3_pend2", O_PEND, 4'b0100); step();
    expect_out("t3_held", O_REQ, 0); step();
    irq_ret = 1'b1; expect_out("t3_pop_lvl", O_LVL, 1); expect_out("t3_pop_req", O_REQ, 0); step();
    exp_reqd("t3_id2", 2); step();
    irq_ack = 1'b1; expect_out("t3_lvl2b", O_LVL, 2); step();

    // Fill the stack, hold a pending source while full, then underflow the stack.
    do_reset("rst4");
    cfg(2'd0, 4'b1111); step();
    for (int k = 3; k >= 0; k--) begin
      cfg(2'd3, 4'(1 << k)); step();
      exp_reqd($sformatf("t4_id%0d", k), k); step();
      irq_ack = 1'b1; expect_out($sformatf("t4_lvl_after%0d", k), O_LVL, 4 - k); step();
    end
    cfg(2'd3, 4'b0001); expect_out("t4_pend", O_PEND, 1); step();
    expect_out("t4_full_req", O_REQ, 0); expect_out("t4_full_pend", O_PEND, 1); step();
    irq_ret = 1'b1; expect_out("t4_ret_lvl", O_LVL, 3); expect_out("t4_ret_req", O_REQ, 0); step();
    exp_reqd("t4_served", 0); step();
    cfg(2'd2, 4'b0001); expect_out("t4_clr_pend", O_PEND, 0); step();
    expect_out("t4_clr_req", O_REQ, 0); step();
    for (int j = 2; j >= 0; j--) begin
      irq_ret = 1'b1; expect_out($sformatf("t4_pop_lvl%0d", j), O_LVL, j); step();
    end
    expect_out("t4_no_err", O_ERR, 0); step();
    irq_ret = 1'b1;
    expect_out("t4_err", O_ERR, 1); expect_out("t4_under_lvl", O_LVL, 0); step();
    expect_out("t4_err_sticky", O_ERR, 1); step();

    // Set wins over pending clear; clear alone works.
    do_reset("rst5");
    cfg(2'd1, 4'b0010); step();
    irq_src = 4'b0010; cfg(2'd2, 4'b0010);
    expect_out("t5_set_wins", O_PEND, 4'b0010); step();
    irq_src = 4'b0000; cfg(2'd2, 4'b0010);
    expect_out("t5_clr", O_PEND, 0); step();

    // Simultaneous ack and return replaces the stack top.
    do_reset("rst5b");
    cfg(2'd0, 4'b1111); step();
    cfg(2'd3, 4'b1000); step();
    exp_reqd("t5_id3", 3); step();
    irq_ack = 1'b1; expect_out("t5_lvl1", O_LVL, 1); step();
    cfg(2'd3, 4'b0010); step();
    exp_reqd("t5_id1", 1); step();
    irq_ack = 1'b1; irq_ret = 1'b1;
    expect_out("t5_ackret_lvl", O_LVL, 1); expect_out("t5_ackret_req", O_REQ, 0);
    expect_out("t5_ackret_pend", O_PEND, 0); step();
    cfg(2'd3, 4'b0100); expect_out("t5_pend2", O_PEND, 4'b0100); step();
    expect_out("t5_top_replaced", O_REQ, 0); step();
    irq_ret = 1'b1; expect_out("t5_ret_lvl", O_LVL, 0); step();
    exp_reqd("t5_id2", 2); step();

    // Reset mid-service, then a masked trigger.
    do_reset("rst6");
    cfg(2'd0, 4'b1111); step();
    cfg(2'd3, 4'b0100); step();
    exp_reqd("t6_id2", 2); step();
    irq_ack = 1'b1; step();
    cfg(2'd3, 4'b0010); step();
    exp_reqd("t6_id1", 1); step();
    irq_ack = 1'b1; step();
    cfg(2'd0, 4'b0000); step();
    cfg(2'd3, 4'b1010);
    expect_out("t6_pre_pend", O_PEND, 4'b1010); expect_out("t6_pre_lvl", O_LVL, 2); step();
    do_reset("t6_mid_rst");
    cfg(2'd3, 4'b0001);
    expect_out("t6_mask_pend", O_PEND, 1); expect_out("t6_mask_req0", O_REQ, 0); step();
    expect_out("t6_mask_req1", O_REQ, 0); step();
    expect_out("t6_mask_req2", O_REQ, 0); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller that generalises the CPU's single `i_timer` interrupt input to N_IRQ prioritised sources.
- Per-source features: enable mask, edge/level mode, software trigger, pending clear.
- Nested-interrupt tracking with a priority stack.
- Sits between the peripheral interrupt lines and the control unit. It supplies request, vector and ID, and consumes the accept (`irq_ack`) and return-from-interrupt (`irq_ret`) strobes from the control unit.

Parameters:
- N_IRQ, 4, number of interrupt sources (2..8); index 0 is highest priority.
- VEC_W, 10, width of the vector (program address) output.
- VEC_BASE, 1008, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive source vectors.
- NEST_DEPTH, 4, maximum number of simultaneously active (nested) interrupts.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_src  in  N_IRQ  raw interrupt sources, synchronous to clk.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  2  target of the write: 0=mask, 1=mode (1=edge, 0=level), 2=pending clear (write-1-clear), 3=software trigger (write-1-set).
- cfg_wdata  in  N_IRQ  configuration write data.
- irq_ack  in  1  CPU accepts the presented interrupt this cycle.
- irq_ret  in  1  CPU executes return-from-interrupt this cycle.
- irq_req  out  1  interrupt request to the control unit (registered).
- irq_id  out  clog2(N_IRQ)  ID of the requested source (registered).
- irq_vec  out  VEC_W  jump address, VEC_BASE + irq_id*VEC_STRIDE, truncated to VEC_W (registered).
- pending  out  N_IRQ  pending register.
- nest_level  out  clog2(NEST_DEPTH+1)  number of active interrupts.
- irq_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (synchronous) values:
  - pending=0, mask=0, mode=0, edge-history=0.
  - Stack empty, nest_level=0.
  - irq_req=0, irq_id=0, irq_vec=VEC_BASE, irq_err=0.
- Pending set conditions, per bit i, at each clock:
  - edge mode: set on irq_src[i]=1 while history[i]=0; history[i] takes irq_src[i] every cycle.
  - level mode: set every cycle irq_src[i]=1.
  - software trigger write: set where cfg_wdata[i]=1.
- Pending clear: by a pending-clear write (cfg_wdata[i]=1), or by an accepted ack for id i. Any set condition in the same cycle wins over a clear.
- Mask or mode writes never alter pending.
- Arbitration (combinational, from current state):
  - eligible = pending & mask; winner = lowest eligible index.
  - preempt_ok = (nest_level==0) or (winner < stack top), and nest_level < NEST_DEPTH.
- Registered outputs: at each clock edge, irq_req <= |eligible & preempt_ok & ~accept_this_cycle; irq_id/irq_vec <= winner when a request is formed, otherwise they hold.
- Latency:
  - Source sampled high at edge t gives pending=1 after edge t and irq_req=1 after edge t+1 (2 cycles).
  - Software trigger has the same latency.
- Accept: accept = irq_ack & irq_req. It clears pending[irq_id] (unless re-set that cycle), pushes irq_id and increments nest_level. irq_req is 0 the following cycle.
  - irq_ack while irq_req=0 is ignored.
  - The presented irq_id is honoured even if mask changed in the same cycle.
- Return: irq_ret pops the stack and decrements nest_level.
  - irq_ret with nest_level==0: no pop, irq_err<=1.
- Simultaneous accept and ret: pop first, then push. nest_level is unchanged and the top is replaced by the new id.
- Stack full (nest_level==NEST_DEPTH): no request is raised; pending bits are retained and serviced after a return.
  - Accept while full cannot occur, since irq_req is gated; if forced, it is ignored and irq_err<=1.
- Equal or lower priority than the stack top never preempts. It is requested after returns bring the top below it, or the stack empties.
- Reset mid-service: stack, nest_level and all pending state are cleared immediately on that edge.

Test Plan:
- Defaults, mask=4'b1111, mode=4'b0001 (edge on source 0); pulse irq_src[0] 1 cycle at edge t -> pending[0]=1 after t, irq_req=1, irq_id=0, irq_vec=1008 after t+1. Hold irq_src[0] high 10 more cycles after ack -> no second request.
- Level source 2 held high, mask=4'b0100 -> irq_req, irq_id=2, irq_vec=1016. Ack while src still high -> irq_req=0 next cycle, pending[2] re-set. Blocked as equal priority while nest_level=1; requested again after irq_ret.
- Nesting: accept id 3 (vec 1020), then software-trigger bit 1 -> irq_id=1 preempts, nest_level=2. Trigger bit 2 -> no request until one irq_ret pops id 1; then id 2 is requested (preempting 3).
- Fill stack: 4 nested accepts at ids 3,2,1,0 -> nest_level=4. Further triggers are held pending with irq_req=0. irq_ret with nest_level=0 after 4 returns plus 1 extra -> irq_err=1 sticky.
- Same cycle: pending-clear write and edge on bit 1 -> pending[1]=1. irq_ack and irq_ret together with nest_level=1 -> nest_level stays 1, top = new id.
- Assert reset with nest_level=2 and pending=4'b1010 -> next cycle all outputs at reset values. Mask=0 with a trigger on bit 0 -> pending[0]=1, irq_req stays 0.
